// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end feeding the decode stage. It owns the fetch PC,
// issues one outstanding read at a time to instruction memory, and captures
// the returned word into a single IF/ID register that decode drains with a
// valid/ready handshake. Redirects from branch/jump resolution replace the
// fetch PC, flush IF/ID and discard any response made stale by the redirect.
//
// Handshake: the IF/ID register is transferred to decode in every cycle where
// if_valid && id_ready. While if_valid && !id_ready, if_valid, if_pc and
// if_instr hold their values. A new memory request is only issued when the
// IF/ID register is empty or draining in the same cycle, so a returning word
// always finds the register free.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req, imem_addr     read request pulse and address (= fetch_pc)
//   imem_rvalid, imem_rdata read response
//   redirect_valid/_pc      change of flow; redirect_pc[1:0] are ignored
//   id_ready                decode accepts IF/ID this cycle
//   if_valid/if_pc/if_instr IF/ID register contents
//   fetch_pc                current fetch PC
//   perf_stall_cnt          decode-stall cycle counter
//
// Configuration macro: FETCH_PERF_EN builds the saturating stall counter;
// without it perf_stall_cnt is tied to zero.
//
// The FSM state is held in the internal signal 'state' (S_REQ/S_WAIT/S_DROP).
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic [15:0]     perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] redirect_target;
  logic            capture;
  logic            unused_redirect_lo;

  assign redirect_target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign imem_addr          = fetch_pc;

  // A response is only kept when it belongs to the current fetch PC.
  assign capture = (state == S_WAIT) && imem_rvalid && !redirect_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_REQ: begin
        if (imem_req) state_next = S_WAIT;
      end
      S_WAIT: begin
        // A redirect with no response yet leaves a stale read in flight.
        if (imem_rvalid)         state_next = S_REQ;
        else if (redirect_valid) state_next = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    if (state == S_REQ)
      imem_req = !reset && !redirect_valid && (!if_valid || id_ready);
  end

  // ---------------------------------------------------------------------------
  // Fetch PC and IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      // Redirect outranks capture and drain; if_pc is left as-is.
      fetch_pc <= redirect_target;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (capture) begin
      fetch_pc <= fetch_pc + PC_STEP;
      if_valid <= 1'b1;
      if_pc    <= fetch_pc;
      if_instr <= imem_rdata;
    end else if (if_valid && id_ready) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-stall counter
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= 16'h0000;
    else if (if_valid && !id_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'h0001;
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the pipeline decode stage.
- Owns the fetch PC and issues single-outstanding read requests to the instruction memory.
- Captures returned words into one IF/ID output register with a valid/ready handshake.
- Handles redirects from the branch/jump resolution stage, including discarding an in-flight response made stale by the redirect.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, fetch PC value after reset.
- NOP_INSTR, 32'h0000_0013, value held on if_instr when invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request strobe; one-cycle pulse per request.
- imem_addr  out  XLEN  read address, valid while imem_req=1 (equals fetch_pc).
- imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req.
- imem_rdata  in  XLEN  instruction word, sampled when imem_rvalid=1.
- redirect_valid  in  1  change fetch PC and flush the IF/ID register.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are forced to 0.
- id_ready  in  1  decode stage accepts the IF/ID contents this cycle.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_pc  out  XLEN  PC of the instruction in the IF/ID register.
- if_instr  out  XLEN  instruction in the IF/ID register.
- fetch_pc  out  XLEN  current fetch PC (debug/top-level observation).
- perf_stall_cnt  out  16  decode-stall cycle counter (see Optional Feature).

Behaviour:
- Reset (synchronous, checked at the clock edge):
  - state=S_REQ, fetch_pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR.
  - imem_req is forced to 0 in any cycle where reset=1.
  - Reset mid-transaction abandons the outstanding request. An imem_rvalid arriving in S_REQ is ignored.
- Handshake:
  - The IF/ID register drains when if_valid && id_ready. It then clears if_valid, sets if_instr to NOP_INSTR, and keeps if_pc.
  - While if_valid && !id_ready, if_valid, if_pc and if_instr are held stable.
- FSM, S_REQ:
  - imem_req = !reset && !redirect_valid && (!if_valid || id_ready).
  - On imem_req=1, go to S_WAIT. Otherwise stay in S_REQ.
- FSM, S_WAIT:
  - imem_req=0.
  - On imem_rvalid: if_valid=1, if_pc=fetch_pc, if_instr=imem_rdata, fetch_pc=fetch_pc+4, go to S_REQ.
  - The issue rule guarantees the IF/ID register is empty at this point. No overflow is possible.
- FSM, S_DROP:
  - imem_req=0.
  - On imem_rvalid, discard the data and go to S_REQ. fetch_pc is unchanged.
- Redirect has top priority in all states:
  - fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - if_valid=0, if_instr=NOP_INSTR.
  - The next state depends on the current state:
    - S_REQ stays in S_REQ, and no request is issued that cycle.
    - S_WAIT without imem_rvalid goes to S_DROP.
    - S_WAIT with imem_rvalid in the same cycle discards the data and goes to S_REQ.
    - S_DROP without imem_rvalid stays in S_DROP.
    - S_DROP with imem_rvalid goes to S_REQ.
  - A redirect in the same cycle as a drain: the redirect wins, and the drain still counts as accepted by decode.
- Arithmetic:
  - fetch_pc+4 wraps modulo 2^XLEN; 0xFFFF_FFFC+4 = 0x0000_0000.
  - No misalignment checks.
- Latency and throughput (1-cycle memory): request at cycle t, rvalid at t+1, if_valid=1 at t+2, next request at t+2. Peak throughput is 1 instruction per 2 cycles.
- Output registering:
  - fetch_pc, if_valid, if_pc, if_instr and perf_stall_cnt are registered.
  - imem_req is combinational from state and inputs.
  - imem_addr = fetch_pc.

Optional Feature:
- Macro name: FETCH_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with if_valid && !id_ready.
  - The counter saturates at 16'hFFFF and resets to 0.
- Undefined:
  - No counter logic is built. perf_stall_cnt is tied to 16'h0000.
  - The port list is identical in both builds.

Test Plan:
- Reset release, 1-cycle memory returning addr>>2 as data, id_ready=1: fetch PCs are 0,4,8,12 and if_instr is 0,1,2,3. if_valid toggles 0,1,0,1 at the 2-cycle cadence.
- id_ready=0 for 5 cycles with if_valid=1: if_pc and if_instr are stable, and imem_req=0 throughout. Resume gives the next request on the first cycle with id_ready=1. With FETCH_PERF_EN, perf_stall_cnt=5.
- redirect_valid with redirect_pc=0x0000_0103 while in S_WAIT, with rvalid 3 cycles later:
  - fetch_pc becomes 0x100 and if_valid drops.
  - The stale word is discarded and never seen on if_valid.
  - The next request has imem_addr=0x100 and if_pc=0x100.
- redirect_valid coincident with imem_rvalid in S_WAIT: the data is dropped, and the next request uses the redirect address on the following cycle.
- RESET_PC=0xFFFF_FFFC: the first instruction has if_pc=0xFFFF_FFFC and the second has if_pc=0x0000_0000.
- Synchronous reset asserted in S_WAIT, with rvalid arriving the cycle after reset deasserts: the response is ignored, if_valid stays 0, and the first request targets RESET_PC.
